// File: rtl/f_fetch_unit.sv
// Fetch stage: owns pc_F, runs the instruction-memory handshake, and holds the
// F/D pipeline register. A fetch that completes during a stall is parked in a
// hold buffer. A branch target seen while the delay slot is still fetching is
// latched, so it is not lost when decode moves on.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] pc_D,
    output logic [31:0] instr_D,
    output logic        valid_D,
    output logic        adel_D
);

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [31:0] hold_word_reg;
    logic [31:0] hold_pc_reg;
    logic        hold_adel_reg;

    logic        redir_valid_reg;
    logic [31:0] redir_pc_reg;

    logic        misaligned;
    logic        fetch_done;
    logic [31:0] fetch_word;
    logic [31:0] fetch_pc;
    logic        fetch_adel;
    logic [31:0] pc_seq;

    // A misaligned PC never goes to memory; it completes locally as a faulting NOP.
    assign misaligned = (pc_F[1:0] != 2'b00);
    assign imem_addr  = pc_F;
    assign pc_seq     = pc_F + 32'd4;

    // Next state, memory request, and the fetch that completes this cycle.
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        fetch_done = 1'b0;
        fetch_word = NOP_INSTR;
        fetch_adel = 1'b0;
        fetch_pc   = pc_F;
        case (state_reg)
            ST_REQ: begin
                imem_req   = !misaligned;
                fetch_done = misaligned || imem_ready;
                fetch_word = misaligned ? NOP_INSTR : imem_rdata;
                fetch_adel = misaligned;
                if (fetch_done && stall) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The buffered fetch counts as completing once the stall lifts.
                fetch_done = 1'b1;
                fetch_word = hold_word_reg;
                fetch_adel = hold_adel_reg;
                fetch_pc   = hold_pc_reg;
                if (!stall) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    // Park a fetch that completes while the pipeline is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_word_reg <= NOP_INSTR;
            hold_adel_reg <= 1'b0;
            hold_pc_reg   <= 32'd0;
        end else if (stall && (state_reg == ST_REQ) && fetch_done) begin
            hold_word_reg <= fetch_word;
            hold_adel_reg <= fetch_adel;
            hold_pc_reg   <= fetch_pc;
        end
    end

    // Fetch PC advances only on a completing fetch, preferring a latched redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F <= RESET_PC;
        end else if (!stall && fetch_done) begin
            pc_F <= redir_valid_reg ? redir_pc_reg : npc;
        end
    end

    // F/D register: real instruction on completion, otherwise a bubble (pc_D kept).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_D    <= 32'd0;
            instr_D <= NOP_INSTR;
            valid_D <= 1'b0;
            adel_D  <= 1'b0;
        end else if (!stall) begin
            if (fetch_done) begin
                pc_D    <= fetch_pc;
                instr_D <= fetch_word;
                valid_D <= 1'b1;
                adel_D  <= fetch_adel;
            end else begin
                instr_D <= NOP_INSTR;
                valid_D <= 1'b0;
                adel_D  <= 1'b0;
            end
        end
    end

    // Latch a non-sequential npc from the instruction leaving D while F still waits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= 32'd0;
        end else if (!stall) begin
            if (fetch_done) begin
                redir_valid_reg <= 1'b0;
            end else if (valid_D && (npc != pc_seq)) begin
                redir_valid_reg <= 1'b1;
                redir_pc_reg    <= npc;
            end
        end
    end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- Fetch-stage PC owner and F/D pipeline register. It is the consumer end of the decode-stage next-PC path.
- Holds pc_F and drives the instruction-memory request/ready handshake. On each completed fetch it loads the next PC from the decode-stage npc, or from a latched redirect.
- Delivers {pc_D, instr_D, valid_D, adel_D} to decode and absorbs hazard stalls and variable-latency memory.

Parameters:
- RESET_PC, 32'h0000_3000, pc_F value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in bubbles and misaligned fetches.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from the decode-stage NPC logic; combinational, valid every cycle.
- stall  in  1  hazard unit freezes F and F/D.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equal to pc_F.
- imem_ready  in  1  memory returns imem_rdata this cycle; may be same-cycle or N cycles later.
- imem_rdata  in  32  fetched word, sampled only when imem_req && imem_ready.
- pc_F  out  32  current fetch PC, fed back to the NPC logic.
- pc_D  out  32  PC of the decode-stage instruction.
- instr_D  out  32  decode-stage instruction.
- valid_D  out  1  instr_D is real (0 = bubble).
- adel_D  out  1  instruction fetch address error for instr_D.

Behaviour:
Reset (asynchronous, while reset==0):
- pc_F=RESET_PC, pc_D=0, instr_D=NOP_INSTR, valid_D=0, adel_D=0.
- State=REQ, hold buffer empty, redir_valid=0, redir_pc=0.

State machine:
- REQ:
  - imem_req = (pc_F[1:0]==0).
  - A fetch completes when imem_req && imem_ready, or immediately if pc_F is misaligned.
- HOLD:
  - Entered when a fetch completes while stall==1.
  - Word, adel flag and fetching PC are stored in the hold buffer; imem_req=0.
  - Stays in HOLD while stall==1.
  - When stall==0, the hold buffer is the completing fetch this cycle and the state returns to REQ.

Next PC on a completing fetch with stall==0:
- pc_F <= redir_valid ? redir_pc : npc.
- F/D <= {pc, word, 1, adel}.
- redir_valid <= 0.

Misaligned pc_F:
- No memory request is issued.
- The fetch completes with word=NOP_INSTR, adel=1, valid=1.
- pc_F then advances normally.

REQ, no completion, stall==0:
- F/D loads a bubble (valid_D=0, instr_D=NOP_INSTR, adel_D=0, pc_D unchanged); pc_F holds.
- Redirect capture: if valid_D==1 and npc != pc_F+4 (modulo 2^32), then redir_pc<=npc and redir_valid<=1.
- This preserves a branch/jump target computed by the instruction leaving D before its delay slot finishes fetching.

REQ, no completion, stall==1:
- Everything holds; imem_req stays asserted.

REQ, completion, stall==1:
- Enter HOLD; pc_F and F/D hold.

stall==1 in any state:
- pc_F, F/D, redir_* never change.

Other rules:
- imem_addr is stable for the whole outstanding request; pc_F changes only on a completing fetch.
- The memory must not raise imem_ready without imem_req.
- A reset mid-request abandons the request. The next request after reset release goes to RESET_PC.
- All PC arithmetic is 32-bit unsigned wrap (32'hFFFF_FFFC+4 = 0).

Test Plan:
- Zero-wait memory, stall=0, npc=pc_F+4 -> pc_F 3000,3004,3008; valid_D=1 from cycle 1 with pc_D lagging pc_F by one cycle.
- Memory ready after 3 cycles at pc_F=3004 -> imem_addr holds 3004 for 3 cycles; valid_D=0 bubbles for 2 cycles, then instr_D=rdata with pc_D=3004.
- Branch in D (pc_D=3000, npc=3100) while the delay slot at 3004 waits 2 cycles -> redir captured; the delay slot is delivered, then pc_F=3100 even though npc is 3008 by then.
- Fetch completes while stall=1 -> state HOLD, imem_req=0, F/D unchanged. Stall drops -> buffered word enters F/D and pc_F<=npc in that same cycle.
- npc=3002 -> no imem_req; next cycle pc_D=3002, adel_D=1, instr_D=0, valid_D=1.
- reset pulled low mid-wait at pc_F=3010 -> immediately pc_F=3000, valid_D=0. After release the first imem_addr is 3000.
